// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor.
//   state_e    : FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//   DEF_WIDTH  : default operand/result width
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - b_in (single bit).
//   a, b, b_in : minuend bit, subtrahend bit, borrow-in
//   d          : difference bit
//   b_out      : borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  // Borrow when b beats a outright, or when they tie and a borrow is pending.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Computes a - b - b_in over WIDTH cycles using one borrow flop and one
// full_subtractor cell on the shift-register LSBs.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, honoured only in IDLE
//   a, b, b_in : operands and borrow-in, captured on the accepting edge
//   busy       : high throughout RUN
//   done       : one-cycle pulse, result valid
//   d          : difference mod 2^WIDTH (held until next DONE or reset)
//   b_out      : unsigned borrow-out (a < b + b_in)
//   ovf        : signed overflow flag
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             a_msb_q, b_msb_q;
  logic             busy_q, done_q, b_out_q, ovf_q;
  logic [WIDTH-1:0] d_q;

  logic             di, br_d;
  logic [WIDTH-1:0] res_d;

  full_subtractor u_fs (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .b_in  (br_q),
    .d     (di),
    .b_out (br_d)
  );

  // Result fills from the top; after WIDTH shifts bit 0 holds the first LSB.
  assign res_d = {di, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= b_in;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            d_q     <= res_d;
            b_out_q <= br_d;
            // Operands of opposite sign and result sign differs from a.
            ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d     = d_q;
  assign b_out = b_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } exp_t;

  logic         clk, rst_n, start, b_in;
  logic [W-1:0] a, b;
  logic         busy, done, b_out, ovf;
  logic [W-1:0] d;

  exp_t         sb_q[$];
  int           n_chk = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  logic [W-1:0] last_d = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t       r;
    logic [W:0] full;
    full  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    r.d   = full[W-1:0];
    r.bo  = full[W];
    r.ovf = (x[W-1] != y[W-1]) && (r.d[W-1] != x[W-1]);
    return r;
  endfunction

  // Called at a negedge; returns at the following negedge with start low.
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input bit push);
    a = x; b = y; b_in = bi; start = 1'b1;
    if (push) sb_q.push_back(model(x, y, bi));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
  endtask

  task automatic wait_done(input int exp_busy);
    int   nb = 0;
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < 4 * W; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) begin
        nb++;
        chk("d_hold_in_run", d, last_d);
      end
      @(negedge clk);
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_cycles", nb, exp_busy);
      chk("busy_low_in_done", busy, 0);
      if (sb_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("d", d, e.d);
        chk("b_out", b_out, e.bo);
        chk("ovf", ovf, e.ovf);
        last_d = e.d;
      end
      @(negedge clk);
      chk("done_single_pulse", done, 0);
    end
  endtask

  logic [W-1:0] ta[6] = '{8'd100, 8'd5, 8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [W-1:0] tb_[6] = '{8'd37, 8'd9, 8'h01, 8'hFF, 8'h00, 8'h00};
  logic         tbi[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int dc0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d", d, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive_start(ta[i], tb_[i], tbi[i], 1);
      wait_done(W);
    end

    // Start during RUN must be ignored.
    drive_start(8'd20, 8'd3, 1'b0, 1);
    @(negedge clk); @(negedge clk);
    start = 1'b1; a = 8'd1; b = 8'd2; b_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    dc0 = done_cnt;
    wait_done(W - 3);
    repeat (3) @(negedge clk);
    chk("one_done_pulse", done_cnt - dc0, 1);
    chk("no_restart", busy, 0);

    // Asynchronous reset mid-RUN aborts the operation.
    drive_start(8'd50, 8'd20, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_d", d, 0);
    chk("abort_b_out", b_out, 0);
    chk("abort_ovf", ovf, 0);
    dc0 = done_cnt;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_idle", busy, 0);
    last_d = '0;
    drive_start(8'd9, 8'd4, 1'b0, 1);
    wait_done(W);

    for (int i = 0; i < 8; i++) begin
      drive_start(W'($urandom), W'($urandom), 1'($urandom), 1);
      wait_done(W);
    end

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor. It computes a - b - b_in, one bit per clock, LSB first, using a single borrow flip-flop and one full-subtractor bit cell. It is the inverse-arithmetic counterpart of the ripple adder datapath and targets area-constrained ALU paths where a WIDTH-cycle latency is acceptable. A start/busy/done handshake lets a sequencer or testbench drive it.

Parameters:
WIDTH, 8, operand and result width in bits (legal range WIDTH >= 2)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; sampled at the accepting edge only
b  input  WIDTH  subtrahend; sampled at the accepting edge only
b_in  input  1  borrow-in; sampled at the accepting edge only
busy  output  1  high while the operation is in progress (RUN)
done  output  1  one-cycle pulse: result valid
d  output  WIDTH  difference, a - b - b_in mod 2^WIDTH
b_out  output  1  unsigned borrow-out; 1 when a < b + b_in
ovf  output  1  signed overflow flag

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- State machine: IDLE -> RUN -> DONE -> IDLE. Encoding is given by shared constants.
- Reset (rst_n low), asynchronous and immediate:
  - state = IDLE.
  - busy, done, d, b_out and ovf all 0.
  - Internal shift registers, bit counter and borrow flip-flop all 0.
- IDLE: start=1 at edge k moves to RUN. At that edge:
  - a and b load into shift registers sa and sb.
  - Borrow flip-flop br loads b_in.
  - Counter loads 0.
  - a[WIDTH-1] and b[WIDTH-1] are latched for the overflow calculation.
  - start=0 keeps the block in IDLE.
- RUN, edges k+1 .. k+WIDTH, one bit per edge:
  - di = sa[0] ^ sb[0] ^ br.
  - br <= (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & br).
  - sa and sb shift right; di shifts into the MSB of the result shift register.
  - Counter increments.
  - busy = 1 throughout RUN.
- At edge k+WIDTH (last bit): move to DONE.
  - d <= completed result register.
  - b_out <= final borrow.
  - ovf <= (a_msb != b_msb) && (d[WIDTH-1] != a_msb), where d[WIDTH-1] is the final result MSB.
  - done = 1 and busy = 0 during the DONE cycle.
- DONE lasts exactly one cycle, then IDLE. done is a registered single-cycle pulse.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accepting edge. Throughput: one operation per WIDTH+2 cycles.
- d, b_out and ovf hold their values until the next DONE or reset. They do not change during a subsequent RUN.
- start while in RUN or DONE is ignored; no queuing.
- a, b and b_in may change freely after the accepting edge without affecting the result.
- Reset mid-operation aborts: no done pulse, outputs return to 0.
- Counter width: $clog2(WIDTH)+1. The terminal compare is against WIDTH-1 in RUN.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Shared package/header sub_pkg: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH constant.
- One sub-module: full_subtractor.
  - Pure combinational bit cell; inputs a, b, b_in; outputs d, b_out.
  - d = a^b^b_in; b_out = (~a&b) | (~(a^b)&b_in).
  - Instantiated once on the LSBs of the shift registers.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- a=8'd100, b=8'd37, b_in=0, start one cycle -> busy high 8 cycles, then done one cycle; d=8'd63, b_out=0, ovf=0.
- a=8'd5, b=8'd9, b_in=0 -> d=8'hFC, b_out=1, ovf=0.
- a=8'h80, b=8'h01, b_in=0 -> d=8'h7F, b_out=0, ovf=1; also a=8'h7F, b=8'hFF -> d=8'h80, ovf=1, b_out=1.
- a=8'h00, b=8'h00, b_in=1 -> d=8'hFF, b_out=1, ovf=0; the borrow-in chain propagates through all 8 bits.
- Start with a=20, b=3; at RUN cycle 3 pulse start with a=1, b=2 -> second start ignored; d=8'd17; exactly one done pulse.
- rst_n low asynchronously at RUN cycle 4 -> busy, done, d, b_out, ovf go 0 immediately, no done pulse; after release, a=9, b=4 -> d=8'd5 after normal latency.
